// File: rtl/jpeg_sched_pkg.sv
// Shared types for the JPEG DCT channel scheduler: channel/mode enums, the
// in-flight tag, and the MCU issue-order lookup.
package jpeg_sched_pkg;

    typedef enum logic [1:0] {CH_Y = 2'd0, CH_CB = 2'd1, CH_CR = 2'd2} ch_e;
    typedef enum logic {MODE_444 = 1'b0, MODE_420 = 1'b1} mode_e;

    typedef struct packed {
        logic last;
        ch_e  ch;
    } tag_t;

    localparam int SEQ_LEN_444 = 3;
    localparam int SEQ_LEN_420 = 6;

    function automatic ch_e seq_channel(input mode_e mode, input logic [2:0] idx);
        if (mode == MODE_444) begin
            case (idx)
                3'd1:    return CH_CB;
                3'd2:    return CH_CR;
                default: return CH_Y;
            endcase
        end else begin
            case (idx)
                3'd4:    return CH_CB;
                3'd5:    return CH_CR;
                default: return CH_Y;
            endcase
        end
    endfunction

    function automatic logic seq_last(input mode_e mode, input logic [2:0] idx);
        return idx == ((mode == MODE_444) ? 3'(SEQ_LEN_444 - 1) : 3'(SEQ_LEN_420 - 1));
    endfunction

endpackage

// File: rtl/sched_tag_fifo.sv
// Tag FIFO tracking which channel owns each block inside the DCT pipeline.
// DEPTH must be a power of two, at least 2.
module sched_tag_fifo
    import jpeg_sched_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  tag_t          push_tag,
    input  logic          pop,
    output tag_t          head,
    output logic [CW-1:0] count
);

    tag_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: count alone says which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_tag;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/jpeg_dct_channel_scheduler.sv
// Time-shares one 2-D DCT core between the Y/Cb/Cr block streams in strict
// MCU order and routes each result back to its originating channel.
module jpeg_dct_channel_scheduler
    import jpeg_sched_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int PIXEL_COUNT  = 64,
    parameter  int MAX_INFLIGHT = 4,
    localparam int BLK_W        = DATA_WIDTH * PIXEL_COUNT,
    localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_mode,
    input  logic [2:0]         ch_in_valid,
    output logic [2:0]         ch_in_ready,
    input  logic [3*BLK_W-1:0] ch_in_data,
    output logic               dct_in_valid,
    input  logic               dct_in_ready,
    output logic [BLK_W-1:0]   dct_in_data,
    input  logic               dct_out_valid,
    output logic               dct_out_ready,
    input  logic [BLK_W-1:0]   dct_out_data,
    output logic [2:0]         ch_out_valid,
    input  logic [2:0]         ch_out_ready,
    output logic [BLK_W-1:0]   ch_out_data,
    output logic               mcu_done,
    output logic [CNT_W-1:0]   inflight,
    output logic               err_orphan
);

    logic [2:0] seq_idx;
    mode_e      mode_q;
    ch_e        sched;
    logic       last;
    logic       full, empty;
    logic       issue_ok, ret_ok;
    logic       in_fire, out_fire;
    tag_t       head;

    assign sched = seq_channel(mode_q, seq_idx);
    assign last  = seq_last(mode_q, seq_idx);
    assign full  = (inflight == CNT_W'(MAX_INFLIGHT));
    assign empty = (inflight == '0);

    // Handshakes are gated by reset so nothing leaks out while reset_n is low.
    assign issue_ok     = reset_n & ~full;
    assign ret_ok       = reset_n & ~empty;

    assign dct_in_valid = ch_in_valid[sched] & issue_ok;
    assign dct_in_data  = ch_in_data[int'(sched)*BLK_W +: BLK_W];
    assign in_fire      = dct_in_valid & dct_in_ready;

    always_comb begin
        ch_in_ready        = '0;
        ch_in_ready[sched] = dct_in_ready & issue_ok;
    end

    always_comb begin
        ch_out_valid          = '0;
        ch_out_valid[head.ch] = dct_out_valid & ret_ok;
    end

    assign dct_out_ready = ch_out_ready[head.ch] & ret_ok;
    assign out_fire      = dct_out_valid & dct_out_ready;
    assign ch_out_data   = dct_out_data;

    // The MCU format is latched at every cycle spent at index 0, then frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_idx    <= '0;
            mode_q     <= MODE_444;
            mcu_done   <= 1'b0;
            err_orphan <= 1'b0;
        end else begin
            if (seq_idx == '0) mode_q <= mode_e'(cfg_mode);
            if (in_fire) seq_idx <= last ? 3'd0 : seq_idx + 3'd1;
            mcu_done <= out_fire & head.last;
            if (dct_out_valid & empty) err_orphan <= 1'b1;
        end
    end

    sched_tag_fifo #(.DEPTH(MAX_INFLIGHT)) u_tag_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (in_fire),
        .push_tag ('{last: last, ch: sched}),
        .pop      (out_fire),
        .head     (head),
        .count    (inflight)
    );

endmodule

// File: tb/tb_jpeg_dct_channel_scheduler.sv
// Directed bench for the DCT channel scheduler with a latency-3 DCT model.
module tb_jpeg_dct_channel_scheduler;

    localparam int DW  = 8;
    localparam int PC  = 4;
    localparam int BW  = DW * PC;
    localparam int MI  = 4;
    localparam int CW  = $clog2(MI) + 1;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_mode;
    logic [2:0]    ch_in_valid;
    logic [2:0]    ch_in_ready;
    logic [3*BW-1:0] ch_in_data;
    logic          dct_in_valid;
    logic          dct_in_ready;
    logic [BW-1:0] dct_in_data;
    logic          dct_out_valid;
    logic          dct_out_ready;
    logic [BW-1:0] dct_out_data;
    logic [2:0]    ch_out_valid;
    logic [2:0]    ch_out_ready;
    logic [BW-1:0] ch_out_data;
    logic          mcu_done;
    logic [CW-1:0] inflight;
    logic          err_orphan;

    logic          mdl_en, mdl_valid, inj_valid;
    logic [BW-1:0] mdl_data, inj_data;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    assign dct_out_valid = mdl_en ? mdl_valid : inj_valid;
    assign dct_out_data  = mdl_en ? mdl_data  : inj_data;

    jpeg_dct_channel_scheduler #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_mode(cfg_mode),
        .ch_in_valid(ch_in_valid), .ch_in_ready(ch_in_ready), .ch_in_data(ch_in_data),
        .dct_in_valid(dct_in_valid), .dct_in_ready(dct_in_ready), .dct_in_data(dct_in_data),
        .dct_out_valid(dct_out_valid), .dct_out_ready(dct_out_ready), .dct_out_data(dct_out_data),
        .ch_out_valid(ch_out_valid), .ch_out_ready(ch_out_ready), .ch_out_data(ch_out_data),
        .mcu_done(mcu_done), .inflight(inflight), .err_orphan(err_orphan)
    );

    function automatic logic [BW-1:0] pat(input logic [2:0] oh);
        case (oh)
            3'b001:  return 32'h1111_1111;
            3'b010:  return 32'h2222_2222;
            3'b100:  return 32'h3333_3333;
            default: return '0;
        endcase
    endfunction

    function automatic logic [2:0] oh_of(input byte c);
        case (c)
            "Y":     return 3'b001;
            "B":     return 3'b010;
            "R":     return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // DCT stand-in: fixed latency, in-order, holds its output under backpressure.
    typedef struct { int t; logic [BW-1:0] d; } mdl_t;
    mdl_t mq[$];
    int   cyc = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            mdl_valid <= 1'b0;
        end else if (mdl_en) begin
            if (mdl_valid && dct_out_ready) void'(mq.pop_front());
            if (dct_in_valid && dct_in_ready) mq.push_back('{t: cyc, d: dct_in_data});
            if (mq.size() > 0) begin
                mdl_valid <= (cyc - mq[0].t >= LAT - 1);
                mdl_data  <= mq[0].d;
            end else begin
                mdl_valid <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    logic [2:0]    iss_ch[$];
    logic [BW-1:0] iss_data[$];
    logic [2:0]    del_ch[$];
    logic [BW-1:0] del_data[$];
    int            pulses = 0;
    int            bad_pulse = 0;
    logic          prev_cr = 1'b0;

    always @(posedge clk) begin
        if (reset_n) begin
            if (dct_in_valid && dct_in_ready) begin
                iss_ch.push_back(ch_in_ready);
                iss_data.push_back(dct_in_data);
            end
            if (|(ch_out_valid & ch_out_ready)) begin
                del_ch.push_back(ch_out_valid & ch_out_ready);
                del_data.push_back(ch_out_data);
            end
            if (mcu_done) begin
                pulses <= pulses + 1;
                if (!prev_cr) bad_pulse <= bad_pulse + 1;
            end
            prev_cr <= ch_out_valid[2] & ch_out_ready[2];
        end else begin
            prev_cr <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        int i = 0;
        while (inflight !== '0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        chk(tag, 64'(inflight), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_seq(input string tag, input int ib, input int db, input string exp,
                           input int pb, input int bb, input int np);
        chk({tag, "_niss"}, 64'(iss_ch.size() - ib), 64'(exp.len()));
        chk({tag, "_ndel"}, 64'(del_ch.size() - db), 64'(exp.len()));
        for (int i = 0; i < exp.len(); i++) begin
            if (ib + i < iss_ch.size()) begin
                chk({tag, "_iss_ch"}, 64'(iss_ch[ib+i]), 64'(oh_of(exp[i])));
                chk({tag, "_iss_data"}, 64'(iss_data[ib+i]), 64'(pat(oh_of(exp[i]))));
            end
            if (db + i < del_ch.size()) begin
                chk({tag, "_del_ch"}, 64'(del_ch[db+i]), 64'(oh_of(exp[i])));
                chk({tag, "_del_data"}, 64'(del_data[db+i]), 64'(pat(oh_of(exp[i]))));
            end
        end
        chk({tag, "_mcu_done"}, 64'(pulses - pb), 64'(np));
        chk({tag, "_mcu_align"}, 64'(bad_pulse - bb), 64'd0);
    endtask

    initial begin
        int ib, db, pb, bb;
        reset_n = 1'b0; cfg_mode = 1'b0; ch_in_valid = 3'b111; dct_in_ready = 1'b1;
        ch_out_ready = 3'b111; mdl_en = 1'b1; inj_valid = 1'b0; inj_data = 32'hDEAD_BEEF;
        ch_in_data = {pat(3'b100), pat(3'b010), pat(3'b001)};

        // Reset: every handshake output forced low, state at reset values.
        repeat (2) @(negedge clk);
        chk("rst_ch_in_ready", 64'(ch_in_ready), 64'd0);
        chk("rst_dct_in_valid", 64'(dct_in_valid), 64'd0);
        chk("rst_ch_out_valid", 64'(ch_out_valid), 64'd0);
        chk("rst_dct_out_ready", 64'(dct_out_ready), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_mcu_done", 64'(mcu_done), 64'd0);
        chk("rst_err_orphan", 64'(err_orphan), 64'd0);
        ch_in_valid = 3'b000;
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_ready_y", 64'(ch_in_ready), 64'b001);
        chk("idle_no_valid", 64'(dct_in_valid), 64'd0);

        // 4:4:4 streaming, one block per cycle.
        ib = iss_ch.size(); db = del_ch.size(); pb = pulses; bb = bad_pulse;
        ch_in_valid = 3'b111;
        #1;
        chk("s444_valid", 64'(dct_in_valid), 64'd1);
        chk("s444_rdy0", 64'(ch_in_ready), 64'b001);
        @(negedge clk); #1;
        chk("s444_rdy1", 64'(ch_in_ready), 64'b010);
        repeat (8) @(negedge clk);
        ch_in_valid = 3'b000;
        drain("s444_drain");
        chk_seq("s444", ib, db, "YBRYBRYBR", pb, bb, 3);

        // 4:2:0 streaming.
        ib = iss_ch.size(); db = del_ch.size(); pb = pulses; bb = bad_pulse;
        cfg_mode = 1'b1; ch_in_valid = 3'b111;
        repeat (12) @(negedge clk);
        ch_in_valid = 3'b000;
        drain("s420_drain");
        chk_seq("s420", ib, db, "YYYYBRYYYYBR", pb, bb, 2);

        // Cb alone cannot jump ahead of Y.
        ib = iss_ch.size(); db = del_ch.size(); pb = pulses; bb = bad_pulse;
        cfg_mode = 1'b0; ch_in_valid = 3'b010;
        repeat (2) @(negedge clk); #1;
        chk("cbw_rdy_cb_cr", 64'(ch_in_ready[2:1]), 64'd0);
        chk("cbw_no_valid", 64'(dct_in_valid), 64'd0);
        chk("cbw_no_issue", 64'(iss_ch.size() - ib), 64'd0);
        ch_in_valid = 3'b011; #1;
        chk("cbw_y_rdy", 64'(ch_in_ready), 64'b001);
        chk("cbw_y_valid", 64'(dct_in_valid), 64'd1);
        @(negedge clk); #1;
        chk("cbw_cb_rdy", 64'(ch_in_ready), 64'b010);
        chk("cbw_cb_valid", 64'(dct_in_valid), 64'd1);
        @(negedge clk);
        ch_in_valid = 3'b100;
        @(negedge clk);
        ch_in_valid = 3'b000;
        drain("cbw_drain");
        chk_seq("cbw", ib, db, "YBR", pb, bb, 1);

        // Backpressure fills the tag FIFO, then drains in order.
        ib = iss_ch.size(); db = del_ch.size(); pb = pulses; bb = bad_pulse;
        ch_out_ready = 3'b000; ch_in_valid = 3'b111;
        for (int i = 0; i < 20 && inflight !== CW'(MI); i++) @(negedge clk);
        #1;
        chk("bp_full", 64'(inflight), 64'(MI));
        chk("bp_in_rdy", 64'(ch_in_ready), 64'd0);
        chk("bp_in_valid", 64'(dct_in_valid), 64'd0);
        chk("bp_out_valid", 64'(ch_out_valid), 64'b001);
        chk("bp_out_rdy", 64'(dct_out_ready), 64'd0);
        repeat (3) @(negedge clk);
        chk("bp_hold", 64'(inflight), 64'(MI));
        chk("bp_hold_iss", 64'(iss_ch.size() - ib), 64'd4);
        ch_out_ready = 3'b111; #1;
        chk("bp_rel_out_rdy", 64'(dct_out_ready), 64'd1);
        chk("bp_rel_no_push", 64'(dct_in_valid), 64'd0);
        @(negedge clk); #1;
        chk("bp_rel_cnt", 64'(inflight), 64'(MI - 1));
        chk("bp_both_in", 64'(dct_in_valid), 64'd1);
        chk("bp_both_out", 64'(ch_out_valid), 64'b010);
        @(negedge clk);
        chk("bp_pushpop", 64'(inflight), 64'(MI - 1));
        ch_in_valid = 3'b100;
        @(negedge clk);
        ch_in_valid = 3'b000;
        drain("bp_drain");
        chk_seq("bp", ib, db, "YBRYBR", pb, bb, 2);

        // Mode change mid-MCU takes effect at the next MCU.
        ib = iss_ch.size(); db = del_ch.size(); pb = pulses; bb = bad_pulse;
        cfg_mode = 1'b0; ch_in_valid = 3'b111;
        @(negedge clk);
        cfg_mode = 1'b1;
        repeat (8) @(negedge clk);
        ch_in_valid = 3'b000;
        drain("mode_drain");
        chk_seq("mode", ib, db, "YBRYYYYBR", pb, bb, 2);

        // Orphan DCT output: nothing delivered, sticky error.
        mdl_en = 1'b0; inj_valid = 1'b1; #1;
        chk("orph_out_valid", 64'(ch_out_valid), 64'd0);
        chk("orph_out_rdy", 64'(dct_out_ready), 64'd0);
        chk("orph_bus", 64'(ch_out_data), 64'(32'hDEAD_BEEF));
        chk("orph_pre", 64'(err_orphan), 64'd0);
        @(negedge clk);
        chk("orph_set", 64'(err_orphan), 64'd1);
        inj_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("orph_sticky", 64'(err_orphan), 64'd1);

        // Async reset mid-stream.
        mdl_en = 1'b1; ch_out_ready = 3'b000; cfg_mode = 1'b0; ch_in_valid = 3'b111;
        repeat (2) @(negedge clk); #1;
        chk("mrst_pre_cnt", 64'(inflight), 64'd2);
        reset_n = 1'b0; #1;
        chk("mrst_inflight", 64'(inflight), 64'd0);
        chk("mrst_err", 64'(err_orphan), 64'd0);
        chk("mrst_in_rdy", 64'(ch_in_ready), 64'd0);
        chk("mrst_in_valid", 64'(dct_in_valid), 64'd0);
        chk("mrst_out_valid", 64'(ch_out_valid), 64'd0);
        chk("mrst_out_rdy", 64'(dct_out_ready), 64'd0);
        chk("mrst_mcu", 64'(mcu_done), 64'd0);
        ch_in_valid = 3'b000;
        @(negedge clk);
        reset_n = 1'b1; #1;
        chk("mrst_seq0", 64'(ch_in_ready), 64'b001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
